// File: rtl/insight_dcache_resp_gen_if.sv
// Bus bundle between the DCache pipeline taps and the Insight DCache response
// trace producer: request/miss/response capture in, trace record and status out.
interface insight_dcache_resp_gen_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_cmd;
    logic              req_signed;
    logic [1:0]        req_size;
    logic              miss_valid;
    logic [ID_W-1:0]   miss_id;
    logic              resp_valid;
    logic [ID_W-1:0]   resp_id;
    logic [31:0]       resp_data;
    logic              flush;
    logic              trace_valid;
    logic              trace_miss;
    logic [ADDR_W-1:0] trace_addr;
    logic [31:0]       trace_rdata;
    logic [ID_W-1:0]   trace_cache_transaction_id;
    logic [4:0]        trace_cache_transaction_cmd;
    logic              trace_cache_transaction_signed;
    logic [1:0]        trace_cache_transaction_size;
    logic [4:0]        occupancy;
    logic              err_dup_id;
    logic              err_unknown_id;
    logic              err_timeout;

    modport master (
        output req_valid, req_id, req_addr, req_cmd, req_signed, req_size,
               miss_valid, miss_id, resp_valid, resp_id, resp_data, flush,
        input  req_ready, trace_valid, trace_miss, trace_addr, trace_rdata,
               trace_cache_transaction_id, trace_cache_transaction_cmd,
               trace_cache_transaction_signed, trace_cache_transaction_size,
               occupancy, err_dup_id, err_unknown_id, err_timeout
    );

    modport slave (
        input  req_valid, req_id, req_addr, req_cmd, req_signed, req_size,
               miss_valid, miss_id, resp_valid, resp_id, resp_data, flush,
        output req_ready, trace_valid, trace_miss, trace_addr, trace_rdata,
               trace_cache_transaction_id, trace_cache_transaction_cmd,
               trace_cache_transaction_signed, trace_cache_transaction_size,
               occupancy, err_dup_id, err_unknown_id, err_timeout
    );
endinterface

// File: rtl/insight_dcache_resp_gen.sv
// Hart-0 DCache response Insight trace producer: tracks accepted requests by id and
// emits one registered trace record per response. Optional age check: INSIGHT_DCACHE_RESP_TIMEOUT_EN.
module insight_dcache_resp_gen #(
    parameter int ENTRIES        = 8,
    parameter int ID_W           = 6,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    insight_dcache_resp_gen_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_missed;
    logic [ENTRIES-1:0] ent_signed;
    logic [ID_W-1:0]    ent_id   [ENTRIES];
    logic [ADDR_W-1:0]  ent_addr [ENTRIES];
    logic [4:0]         ent_cmd  [ENTRIES];
    logic [1:0]         ent_size [ENTRIES];

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               dup_hit;
    logic               resp_hit;
    logic [IDX_W-1:0]   resp_idx;
    logic [ENTRIES-1:0] miss_vec;
    logic [4:0]         occ_count;
    logic               alloc_fire;
    logic               retire_fire;
    logic               miss_fire;

    function automatic logic [31:0] extract_rdata(input logic [4:0] cmd, input logic [1:0] lane,
                                                  input logic [1:0] size, input logic sgn,
                                                  input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic        is_amo;
        logic        is_load;
        b       = data[{lane, 3'b000} +: 8];
        h       = lane[1] ? data[31:16] : data[15:0];
        is_amo  = (cmd == 5'b00100) || (cmd[4:3] == 2'b01);
        is_load = (cmd == 5'b00000) || (cmd == 5'b00110) || is_amo;
        extract_rdata = '0;
        if (is_load) begin
            if (is_amo || size[1])
                extract_rdata = data;
            else if (size[0])
                extract_rdata = {{16{sgn & h[15]}}, h};
            else
                extract_rdata = {{24{sgn & b[7]}}, b};
        end else if (cmd == 5'b00111) begin
            extract_rdata = {31'b0, data[0]};
        end
    endfunction

    // Lookups see only registered entries, so an id being allocated this cycle never matches.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        dup_hit    = 1'b0;
        resp_hit   = 1'b0;
        resp_idx   = '0;
        miss_vec   = '0;
        occ_count  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_valid[i] && ent_id[i] == bus.req_id)
                dup_hit = 1'b1;
            if (ent_valid[i] && ent_id[i] == bus.resp_id) begin
                resp_hit = 1'b1;
                resp_idx = IDX_W'(i);
            end
            miss_vec[i] = ent_valid[i] && (ent_id[i] == bus.miss_id);
            occ_count   = occ_count + 5'(ent_valid[i]);
        end
    end

    assign alloc_fire    = bus.req_valid && free_found && !dup_hit && !bus.flush;
    assign retire_fire   = bus.resp_valid && resp_hit && !bus.flush;
    assign miss_fire     = bus.miss_valid && !bus.flush;
    assign bus.req_ready = free_found;
    assign bus.occupancy = occ_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid  <= '0;
            ent_missed <= '0;
            ent_signed <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_id[i]   <= '0;
                ent_addr[i] <= '0;
                ent_cmd[i]  <= '0;
                ent_size[i] <= '0;
            end
        end else if (bus.flush) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (miss_fire && miss_vec[i])
                    ent_missed[i] <= 1'b1;
                if (retire_fire && resp_idx == IDX_W'(i))
                    ent_valid[i] <= 1'b0;
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    ent_valid[i]  <= 1'b1;
                    ent_missed[i] <= 1'b0;
                    ent_signed[i] <= bus.req_signed;
                    ent_id[i]     <= bus.req_id;
                    ent_addr[i]   <= bus.req_addr;
                    ent_cmd[i]    <= bus.req_cmd;
                    ent_size[i]   <= bus.req_size;
                end
            end
        end
    end

    // Trace fields only load on a retire and otherwise hold the previous record.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.trace_valid                    <= 1'b0;
            bus.trace_miss                     <= 1'b0;
            bus.trace_addr                     <= '0;
            bus.trace_rdata                    <= '0;
            bus.trace_cache_transaction_id     <= '0;
            bus.trace_cache_transaction_cmd    <= '0;
            bus.trace_cache_transaction_signed <= 1'b0;
            bus.trace_cache_transaction_size   <= '0;
            bus.err_dup_id                     <= 1'b0;
            bus.err_unknown_id                 <= 1'b0;
        end else begin
            bus.trace_valid <= retire_fire;
            if (retire_fire) begin
                bus.trace_miss <= ent_missed[resp_idx] ||
                                  (bus.miss_valid && bus.miss_id == bus.resp_id);
                bus.trace_addr                     <= ent_addr[resp_idx];
                bus.trace_rdata                    <= extract_rdata(ent_cmd[resp_idx],
                                                          ent_addr[resp_idx][1:0],
                                                          ent_size[resp_idx],
                                                          ent_signed[resp_idx],
                                                          bus.resp_data);
                bus.trace_cache_transaction_id     <= ent_id[resp_idx];
                bus.trace_cache_transaction_cmd    <= ent_cmd[resp_idx];
                bus.trace_cache_transaction_signed <= ent_signed[resp_idx];
                bus.trace_cache_transaction_size   <= ent_size[resp_idx];
            end
            if (bus.req_valid && free_found && dup_hit && !bus.flush)
                bus.err_dup_id <= 1'b1;
            if (bus.resp_valid && !resp_hit && !bus.flush)
                bus.err_unknown_id <= 1'b1;
        end
    end

`ifdef INSIGHT_DCACHE_RESP_TIMEOUT_EN
    logic [7:0] ent_age [ENTRIES];

    // Error fires on the edge where an entry's age reaches the limit; the entry stays live.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.err_timeout <= 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                ent_age[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    ent_age[i] <= '0;
                end else if (ent_valid[i] && {1'b0, ent_age[i]} < 9'(TIMEOUT_CYCLES)) begin
                    ent_age[i] <= ent_age[i] + 8'd1;
                end
                if (ent_valid[i] && !bus.flush &&
                    ({1'b0, ent_age[i]} + 9'd1) >= 9'(TIMEOUT_CYCLES))
                    bus.err_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign bus.err_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_insight_dcache_resp_gen.sv
// Directed bench for insight_dcache_resp_gen: table of single-cycle vectors plus
// hand-written sequences for table-full, duplicate, unknown-id and flush behaviour.
module tb_insight_dcache_resp_gen;
    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [4:0] M_XWR = 5'b00001;
    localparam logic [4:0] M_XLR = 5'b00110;
    localparam logic [4:0] M_XSC = 5'b00111;
    localparam logic [4:0] M_AMO = 5'b01000;

    typedef struct {
        logic        req_valid;
        logic [5:0]  req_id;
        logic [31:0] req_addr;
        logic [4:0]  req_cmd;
        logic        req_signed;
        logic [1:0]  req_size;
        logic        miss_valid;
        logic [5:0]  miss_id;
        logic        resp_valid;
        logic [5:0]  resp_id;
        logic [31:0] resp_data;
        logic        chk_trace;
        logic        exp_tv;
        logic        exp_miss;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_id;
        logic [4:0]  exp_cmd;
        logic        exp_ready;
        logic [4:0]  exp_occ;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t tbl[$];

    insight_dcache_resp_gen_if #(.ID_W(6), .ADDR_W(32)) bus ();

    insight_dcache_resp_gen #(
        .ENTRIES(8), .ID_W(6), .ADDR_W(32), .TIMEOUT_CYCLES(255)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    function automatic vec_t st(input logic rv, input logic [5:0] rid, input logic [31:0] raddr,
                                input logic [4:0] rcmd, input logic rsg, input logic [1:0] rsz,
                                input logic mv, input logic [5:0] mid,
                                input logic pv, input logic [5:0] pid, input logic [31:0] pdata);
        vec_t v;
        v.req_valid = rv;  v.req_id = rid;  v.req_addr = raddr; v.req_cmd = rcmd;
        v.req_signed = rsg; v.req_size = rsz;
        v.miss_valid = mv; v.miss_id = mid;
        v.resp_valid = pv; v.resp_id = pid; v.resp_data = pdata;
        v.chk_trace = 1'b0; v.exp_tv = 1'b0; v.exp_miss = 1'b0; v.exp_rdata = '0;
        v.exp_id = '0; v.exp_cmd = '0; v.exp_ready = 1'b1; v.exp_occ = '0;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vin, input logic chk, input logic tv, input logic miss,
                                input logic [31:0] rdata, input logic [5:0] id, input logic [4:0] cmd,
                                input logic ready, input logic [4:0] occ);
        vec_t v;
        v = vin;
        v.chk_trace = chk; v.exp_tv = tv; v.exp_miss = miss; v.exp_rdata = rdata;
        v.exp_id = id; v.exp_cmd = cmd; v.exp_ready = ready; v.exp_occ = occ;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.req_valid  = v.req_valid;
        bus.req_id     = v.req_id;
        bus.req_addr   = v.req_addr;
        bus.req_cmd    = v.req_cmd;
        bus.req_signed = v.req_signed;
        bus.req_size   = v.req_size;
        bus.miss_valid = v.miss_valid;
        bus.miss_id    = v.miss_id;
        bus.resp_valid = v.resp_valid;
        bus.resp_id    = v.resp_id;
        bus.resp_data  = v.resp_data;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkVal($sformatf("row%0d trace_valid", idx), 32'(bus.trace_valid), 32'(v.exp_tv));
        checkVal($sformatf("row%0d req_ready", idx), 32'(bus.req_ready), 32'(v.exp_ready));
        checkVal($sformatf("row%0d occupancy", idx), 32'(bus.occupancy), 32'(v.exp_occ));
        checkVal($sformatf("row%0d errors", idx),
                 32'({bus.err_dup_id, bus.err_unknown_id, bus.err_timeout}), 32'd0);
        if (v.chk_trace) begin
            checkVal($sformatf("row%0d trace_miss", idx), 32'(bus.trace_miss), 32'(v.exp_miss));
            checkVal($sformatf("row%0d trace_rdata", idx), bus.trace_rdata, v.exp_rdata);
            checkVal($sformatf("row%0d trace_id", idx),
                     32'(bus.trace_cache_transaction_id), 32'(v.exp_id));
            checkVal($sformatf("row%0d trace_cmd", idx),
                     32'(bus.trace_cache_transaction_cmd), 32'(v.exp_cmd));
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checkVal("reset trace_valid", 32'(bus.trace_valid), 32'd0);
        checkVal("reset trace_rdata", bus.trace_rdata, 32'd0);
        checkVal("reset trace_miss", 32'(bus.trace_miss), 32'd0);
        checkVal("reset occupancy", 32'(bus.occupancy), 32'd0);
        checkVal("reset req_ready", 32'(bus.req_ready), 32'd1);
        checkVal("reset errors",
                 32'({bus.err_dup_id, bus.err_unknown_id, bus.err_timeout}), 32'd0);

        //          req: v  id  addr          cmd    sg sz  miss: v id  resp: v id  data
        tbl.push_back(ex(st(1, 5, 32'h1003, M_XRD, 1, 0, 0, 0,  0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  1, 5,  32'h80FF_FF12), 1, 1, 0, 32'hFFFF_FF80, 5, M_XRD, 1, 0));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  0, 0,  0), 1, 0, 0, 32'hFFFF_FF80, 5, M_XRD, 1, 0));
        tbl.push_back(ex(st(1, 7, 32'h2002, M_XRD, 0, 1, 0, 0,  0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 1, 7,  0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  1, 7,  32'hABCD_1234), 1, 1, 1, 32'h0000_ABCD, 7, M_XRD, 1, 0));
        tbl.push_back(ex(st(1, 10, 32'h100, M_XRD, 1, 2, 0, 0,  0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(1, 11, 32'h201, M_XRD, 1, 1, 1, 10, 1, 10, 32'h1234_5678), 1, 1, 1, 32'h1234_5678, 10, M_XRD, 1, 1));
        tbl.push_back(ex(st(1, 12, 32'h300, M_XSC, 0, 2, 0, 0,  1, 11, 32'h1234_8001), 1, 1, 0, 32'hFFFF_8001, 11, M_XRD, 1, 1));
        tbl.push_back(ex(st(1, 13, 32'h400, M_XWR, 0, 2, 0, 0,  1, 12, 32'hFFFF_FFF3), 1, 1, 0, 32'h0000_0001, 12, M_XSC, 1, 1));
        tbl.push_back(ex(st(1, 14, 32'h500, M_AMO, 0, 2, 0, 0,  1, 13, 32'hDEAD_BEEF), 1, 1, 0, 32'h0000_0000, 13, M_XWR, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  1, 14, 32'h8000_0001), 1, 1, 0, 32'h8000_0001, 14, M_AMO, 1, 0));
        tbl.push_back(ex(st(1, 15, 32'h602, M_XLR, 0, 0, 1, 15, 0, 0,  0), 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(ex(st(0, 0, 0,        0,     0, 0, 0, 0,  1, 15, 32'h00A5_0000), 1, 1, 0, 32'h0000_00A5, 15, M_XLR, 1, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            stepCycle();
            checkOutput(i, tbl[i]);
        end

        // Fill all eight entries, then overflow with a dropped request.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(st(1, 6'(k), 32'(k * 4), M_XRD, 0, 2, 0, 0, 0, 0, 0));
            stepCycle();
        end
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkVal("full req_ready", 32'(bus.req_ready), 32'd0);
        checkVal("full occupancy", 32'(bus.occupancy), 32'd8);
        applyStimulus(st(1, 8, 32'h80, M_XRD, 0, 2, 0, 0, 0, 0, 0));
        stepCycle();
        checkVal("drop occupancy", 32'(bus.occupancy), 32'd8);
        checkVal("drop err_dup_id", 32'(bus.err_dup_id), 32'd0);

        // Retire id 3 while id 9 is refused; the slot becomes usable next cycle.
        applyStimulus(st(1, 9, 32'h90, M_XRD, 0, 2, 0, 0, 1, 3, 32'h3333_3333));
        stepCycle();
        checkVal("retire3 trace_valid", 32'(bus.trace_valid), 32'd1);
        checkVal("retire3 trace_id", 32'(bus.trace_cache_transaction_id), 32'd3);
        checkVal("retire3 trace_addr", bus.trace_addr, 32'hC);
        checkVal("retire3 trace_rdata", bus.trace_rdata, 32'h3333_3333);
        checkVal("retire3 occupancy", 32'(bus.occupancy), 32'd7);
        checkVal("retire3 req_ready", 32'(bus.req_ready), 32'd1);
        applyStimulus(st(1, 9, 32'h94, M_XRD, 0, 2, 0, 0, 0, 0, 0));
        stepCycle();
        checkVal("realloc occupancy", 32'(bus.occupancy), 32'd8);
        checkVal("realloc req_ready", 32'(bus.req_ready), 32'd0);
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0000_0099));
        stepCycle();
        checkVal("resp9 trace_valid", 32'(bus.trace_valid), 32'd1);
        checkVal("resp9 trace_id", 32'(bus.trace_cache_transaction_id), 32'd9);
        checkVal("resp9 trace_addr", bus.trace_addr, 32'h94);
        checkVal("resp9 occupancy", 32'(bus.occupancy), 32'd7);

        // Duplicate id: not allocated, sticky flag raised.
        applyStimulus(st(1, 2, 32'h200, M_XRD, 0, 2, 0, 0, 0, 0, 0));
        stepCycle();
        checkVal("dup err_dup_id", 32'(bus.err_dup_id), 32'd1);
        checkVal("dup occupancy", 32'(bus.occupancy), 32'd7);
        checkVal("dup err_unknown_id", 32'(bus.err_unknown_id), 32'd0);

        // Flush suppresses the same-cycle response and allocation.
        applyStimulus(st(1, 30, 32'h300, M_XRD, 0, 2, 0, 0, 1, 4, 32'h4444_4444));
        bus.flush = 1'b1;
        stepCycle();
        bus.flush = 1'b0;
        checkVal("flush trace_valid", 32'(bus.trace_valid), 32'd0);
        checkVal("flush occupancy", 32'(bus.occupancy), 32'd0);
        checkVal("flush err_unknown_id", 32'(bus.err_unknown_id), 32'd0);
        checkVal("flush err_dup_id", 32'(bus.err_dup_id), 32'd1);
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h4444_4444));
        stepCycle();
        checkVal("postflush trace_valid", 32'(bus.trace_valid), 32'd0);
        checkVal("postflush err_unknown_id", 32'(bus.err_unknown_id), 32'd1);
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 32'h2020_2020));
        stepCycle();
        checkVal("unknown20 trace_valid", 32'(bus.trace_valid), 32'd0);

        // Response for an id allocated in the same cycle does not retire it.
        applyStimulus(st(1, 21, 32'h210, M_XRD, 0, 2, 0, 0, 1, 21, 32'h2121_2121));
        stepCycle();
        checkVal("samecycle trace_valid", 32'(bus.trace_valid), 32'd0);
        checkVal("samecycle occupancy", 32'(bus.occupancy), 32'd1);
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 21, 32'h2121_2121));
        stepCycle();
        checkVal("resp21 trace_valid", 32'(bus.trace_valid), 32'd1);
        checkVal("resp21 trace_id", 32'(bus.trace_cache_transaction_id), 32'd21);
        checkVal("resp21 occupancy", 32'(bus.occupancy), 32'd0);
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef INSIGHT_DCACHE_RESP_TIMEOUT_EN
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        applyStimulus(st(1, 1, 32'h10, M_XRD, 0, 2, 0, 0, 0, 0, 0));
        stepCycle();
        applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (254) stepCycle();
        checkVal("age254 err_timeout", 32'(bus.err_timeout), 32'd0);
        stepCycle();
        checkVal("age255 err_timeout", 32'(bus.err_timeout), 32'd1);
        checkVal("age255 occupancy", 32'(bus.occupancy), 32'd1);
`else
        repeat (300) stepCycle();
        checkVal("idle err_timeout", 32'(bus.err_timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
